// File: rtl/mult10_sequencer_if.sv
// -----------------------------------------------------------------------------
// mult10_sequencer_if
//   Handshake bundle between mult10_sequencer and its neighbours.
//
//   Signals
//     in_valid  : operands a/b present (upstream -> sequencer)
//     in_ready  : sequencer can accept operands (sequencer -> upstream)
//     a, b      : 10-bit unsigned operands
//     out_valid : result valid (sequencer -> downstream)
//     out_ready : downstream accepts result (downstream -> sequencer)
//     result    : 20-bit product a*b
//     busy      : sequencer is multiplying or holding a result
//
//   Modports
//     slave  : the sequencer side
//     master : the surrounding logic / testbench side
// -----------------------------------------------------------------------------
interface mult10_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  a;
  logic [9:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] result;
  logic        busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mult10_sequencer.sv
// -----------------------------------------------------------------------------
// mult10_sequencer
//   Sequential 10x10 unsigned multiplier. Each operand is split into 5-bit
//   halves and the four partial products are formed one per cycle on a single
//   shared 5x5 array_multiplier, then shifted and accumulated into 20 bits.
//
//   Step order: S0 aL*bL <<0, S1 aH*bL <<5, S2 aL*bH <<5, S3 aH*bH <<10.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : mult10_sequencer_if.slave (in_valid/in_ready/a/b,
//              out_valid/out_ready/result, busy)
//
//   Configuration
//     MULT_SEQ_SKIP_ZERO_EN : when defined, steps whose operand halves include
//       a zero are skipped, so latency drops to the number of useful steps
//       (0..4). Undefined: all four steps always run, latency is fixed at 4.
//       The product is identical in both builds.
// -----------------------------------------------------------------------------

// 5x5 -> 10 unsigned array multiplier: sum of AND-gated, shifted rows.
module array_multiplier (
  input  logic [4:0] x,
  input  logic [4:0] y,
  output logic [9:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 5; i++) begin
      p = p + ({5'b0, x & {5{y[i]}}} << i);
    end
  end
endmodule

module mult10_sequencer (
  input  logic                clk,
  input  logic                rst_n,
  mult10_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  step, step_next;
  logic [9:0]  a_q, b_q;
  logic [19:0] acc;

  logic        load;      // accept operands, clear accumulator
  logic        acc_add;   // accumulate current step's shifted product

  logic [3:0]  en_in;     // step enables from the incoming operands
  logic [3:0]  en_q;      // step enables from the latched operands
  logic [2:0]  pick_first;
  logic [2:0]  pick_next;

  logic [4:0]  mul_x, mul_y;
  logic [9:0]  mul_p;
  logic [19:0] addend;

  // Lowest-indexed enabled step at or above 'from'; returns {found, index}.
  function automatic logic [2:0] find_step(input logic [3:0] en,
                                           input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (en[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

`ifdef MULT_SEQ_SKIP_ZERO_EN
  // A step contributes nothing when either of its halves is zero.
  assign en_in = {(bus.a[9:5] != 5'd0) && (bus.b[9:5] != 5'd0),
                  (bus.a[4:0] != 5'd0) && (bus.b[9:5] != 5'd0),
                  (bus.a[9:5] != 5'd0) && (bus.b[4:0] != 5'd0),
                  (bus.a[4:0] != 5'd0) && (bus.b[4:0] != 5'd0)};
  assign en_q  = {(a_q[9:5] != 5'd0) && (b_q[9:5] != 5'd0),
                  (a_q[4:0] != 5'd0) && (b_q[9:5] != 5'd0),
                  (a_q[9:5] != 5'd0) && (b_q[4:0] != 5'd0),
                  (a_q[4:0] != 5'd0) && (b_q[4:0] != 5'd0)};
`else
  assign en_in = 4'b1111;
  assign en_q  = 4'b1111;
`endif

  assign pick_first = find_step(en_in, 3'd0);
  assign pick_next  = find_step(en_q, {1'b0, step} + 3'd1);

  // Step mux into the shared multiplier.
  always_comb begin
    mul_x = a_q[4:0];
    mul_y = b_q[4:0];
    case (step)
      2'd0: begin mul_x = a_q[4:0]; mul_y = b_q[4:0]; end
      2'd1: begin mul_x = a_q[9:5]; mul_y = b_q[4:0]; end
      2'd2: begin mul_x = a_q[4:0]; mul_y = b_q[9:5]; end
      default: begin mul_x = a_q[9:5]; mul_y = b_q[9:5]; end
    endcase
  end

  array_multiplier u_mul (
    .x (mul_x),
    .y (mul_y),
    .p (mul_p)
  );

  // Weight of the partial product: 0, 5, 5 or 10 bits.
  always_comb begin
    case (step)
      2'd0:    addend = {10'b0, mul_p};
      2'd1,
      2'd2:    addend = {5'b0, mul_p, 5'b0};
      default: addend = {mul_p, 10'b0};
    endcase
  end

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    step_next  = step;
    load       = 1'b0;
    acc_add    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load = 1'b1;
          if (pick_first[2]) begin
            step_next  = pick_first[1:0];
            state_next = MUL;
          end else begin
            step_next  = 2'd0;
            state_next = DONE;
          end
        end
      end
      MUL: begin
        acc_add = 1'b1;
        if (pick_next[2]) step_next  = pick_next[1:0];
        else              state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 2'd0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
      if (load) begin
        a_q <= bus.a;
        b_q <= bus.b;
        acc <= '0;
      end else if (acc_add) begin
        acc <= acc + addend;
      end
    end
  end

  // Outputs come from state only; in_ready is additionally held low while
  // reset is asserted so upstream never sees a ready during reset.
  assign bus.in_ready  = (state == IDLE) && rst_n;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == MUL) || (state == DONE);
  // Partial sums are never exposed outside DONE.
  assign bus.result    = (state == DONE) ? acc : 20'd0;

endmodule

// File: tb/tb_mult10_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult10_sequencer
//   Self-checking bench for mult10_sequencer. The reference model computes the
//   product with plain arithmetic and the latency from the count of useful
//   half-products (skip-zero build) or a fixed 4 (default build).
// -----------------------------------------------------------------------------
module tb_mult10_sequencer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mult10_sequencer_if bus ();

  mult10_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_latency(input int ta, input int tb);
`ifdef MULT_SEQ_SKIP_ZERO_EN
    int al, ah, bl, bh, n;
    al = ta % 32; ah = ta / 32; bl = tb % 32; bh = tb / 32;
    n = 0;
    if (al != 0 && bl != 0) n++;
    if (ah != 0 && bl != 0) n++;
    if (al != 0 && bh != 0) n++;
    if (ah != 0 && bh != 0) n++;
    return n;
`else
    return (ta + tb >= 0) ? 4 : 4;
`endif
  endfunction

  // One full transaction: accept, wait for result, optional backpressure
  // with an optional stray in_valid pulse, then the DONE handshake.
  task automatic run_txn(input string tag, input int ta, input int tb,
                         input int hold, input bit poke);
    int lat;
    int exp_lat;
    int waitc;
    logic [19:0] exp_res;
    exp_res = 20'(ta * tb);
    exp_lat = model_latency(ta, tb);

    @(negedge clk);
    waitc = 0;
    while (!bus.in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, ":in_ready_idle"}, 32'(bus.in_ready), 32'd1);

    bus.in_valid = 1'b1;
    bus.a        = 10'(ta);
    bus.b        = 10'(tb);
    @(posedge clk);               // acceptance edge E0
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 10'($urandom);  // operands must already be latched
    bus.b        = 10'($urandom);

    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      check({tag, ":in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      check({tag, ":busy_mul"}, 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":result"}, 32'(bus.result), 32'(exp_res));
    check({tag, ":busy_done"}, 32'(bus.busy), 32'd1);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (poke && h == 0) begin
        bus.in_valid = 1'b1;
        bus.a        = 10'd1023;
        bus.b        = 10'd1023;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ":hold_result"}, 32'(bus.result), 32'(exp_res));
      check({tag, ":hold_busy"}, 32'(bus.busy), 32'd1);
      check({tag, ":hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end

    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);               // DONE handshake edge
    #1;
    bus.out_ready = 1'b0;
    check({tag, ":post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ":post_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, ":post_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int waitc;
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    // Reset state.
    #3;
    check("rst:in_ready", 32'(bus.in_ready), 32'd0);
    check("rst:out_valid", 32'(bus.out_valid), 32'd0);
    check("rst:result", 32'(bus.result), 32'd0);
    check("rst:busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel:in_ready", 32'(bus.in_ready), 32'd1);
    check("rel:out_valid", 32'(bus.out_valid), 32'd0);

    // Directed scenarios.
    run_txn("max", 1023, 1023, 0, 1'b0);
    run_txn("mixed", 37, 500, 0, 1'b0);
    run_txn("b2b", 1023, 1, 0, 1'b0);
    run_txn("bp", 600, 3, 3, 1'b1);

    // Reset during step S2 of 1000*1000.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 10'd1000;
    bus.b        = 10'd1000;
    @(posedge clk);               // E0
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);    // S0, S1 done; S2 now in progress
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst:out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst:result", 32'(bus.result), 32'd0);
    check("midrst:busy", 32'(bus.busy), 32'd0);
    check("midrst:in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // No stale result may appear after release.
    waitc = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) waitc++;
    end
    check("midrst:no_ghost", 32'(waitc), 32'd0);
    run_txn("after_rst", 2, 3, 0, 1'b0);

    // Skip-zero corner operands (latency depends on build).
    run_txn("sz_31x31", 31, 31, 0, 1'b0);
    run_txn("sz_0x777", 0, 777, 1, 1'b0);
    run_txn("sz_32x32", 32, 32, 0, 1'b0);
    run_txn("zero_b", 513, 0, 0, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 30; i++) begin
      int ra, rb;
      ra = int'($urandom_range(0, 1023));
      rb = int'($urandom_range(0, 1023));
      if (i % 7 == 0) ra = ra & 32'h3E0;   // zero low half
      if (i % 5 == 0) rb = rb & 32'h01F;   // zero high half
      run_txn("rand", ra, rb, int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
